// File: rtl/matmul_sequencer_if.sv
// Operand-bank / multiply-array handshake bundle for matmul_sequencer.
// master: the sequencer side (drives bank and array controls, grants host writes).
// slave:  the bank/array/APB side.
interface matmul_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 1
);

  logic                  apb_write_req_i;
  logic                  apb_grant_o;
  logic                  op_write_enable_o;
  logic [ADDR_WIDTH-1:0] op_addr_o;
  logic                  op_valid_o;
  logic                  acc_clear_o;
  logic                  result_we_o;

  modport master (
    input  apb_write_req_i,
    output apb_grant_o,
    output op_write_enable_o,
    output op_addr_o,
    output op_valid_o,
    output acc_clear_o,
    output result_we_o
  );

  modport slave (
    output apb_write_req_i,
    input  apb_grant_o,
    input  op_write_enable_o,
    input  op_addr_o,
    input  op_valid_o,
    input  acc_clear_o,
    input  result_we_o
  );

endinterface

// File: rtl/matmul_sequencer.sv
// Control sequencer for one matrix product on the systolic multiply array.
// Clears the accumulators, streams k operand vectors by address, waits out the
// array pipeline, pulses result write-back and keeps sticky done/error flags.
// Host operand writes are only granted while idle and not starting a run.
module matmul_sequencer #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned BUS_WIDTH  = 64,
  localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter  int unsigned PIPE_LAT   = 2 * (BUS_WIDTH / DATA_WIDTH) - 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [$clog2(MAX_DIM):0]   k_dim_i,
  input  logic                       status_clear_i,
  matmul_sequencer_if.master         bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o
);

  localparam int unsigned KW = $clog2(MAX_DIM) + 1;
  localparam int unsigned AW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_WB
  } state_e;

  state_e          state_q,     state_d;
  logic [KW-1:0]   k_q,         k_d;
  logic [AW-1:0]   addr_q,      addr_d;
  logic [DW-1:0]   drain_q,     drain_d;
  logic            valid_q,     valid_d;
  logic            acc_clear_q, acc_clear_d;
  logic            result_we_q, result_we_d;
  logic            busy_q,      busy_d;
  logic            done_q,      done_d;
  logic            error_q,     error_d;

  logic            start_legal;
  logic            stream_last;
  logic            drain_last;
  logic            grant;

  assign start_legal = (k_dim_i != '0) && (k_dim_i <= KW'(MAX_DIM));
  // The stream counter doubles as the operand address.
  assign stream_last = (KW'(addr_q) == (k_q - KW'(1)));
  assign drain_last  = (drain_q == DW'(PIPE_LAT - 1));
  // Start takes priority over a same-cycle host write.
  assign grant       = (state_q == ST_IDLE) && !start_i;

  // Next-state and next-output decode; outputs are registered alongside state.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    addr_d      = '0;
    drain_d     = drain_q;
    valid_d     = 1'b0;
    acc_clear_d = 1'b0;
    result_we_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE: begin
        if (status_clear_i) begin
          done_d  = 1'b0;
          error_d = 1'b0;
        end
        if (start_i) begin
          if (start_legal) begin
            k_d         = k_dim_i;
            done_d      = 1'b0;
            acc_clear_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_CLEAR;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        addr_d  = '0;
        state_d = ST_STREAM;
      end

      ST_STREAM: begin
        busy_d = 1'b1;
        if (stream_last) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          valid_d = 1'b1;
          addr_d  = addr_q + AW'(1);
        end
      end

      ST_DRAIN: begin
        busy_d = 1'b1;
        if (drain_last) begin
          drain_d     = '0;
          result_we_d = 1'b1;
          state_d     = ST_WB;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end

      ST_WB: begin
        // Run completion sets done even if status_clear_i is high now.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any run immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      addr_q      <= '0;
      drain_q     <= '0;
      valid_q     <= 1'b0;
      acc_clear_q <= 1'b0;
      result_we_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      valid_q     <= valid_d;
      acc_clear_q <= acc_clear_d;
      result_we_q <= result_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.apb_grant_o       = grant;
  assign bus.op_write_enable_o = grant && bus.apb_write_req_i;
  assign bus.op_addr_o         = addr_q;
  assign bus.op_valid_o        = valid_q;
  assign bus.acc_clear_o       = acc_clear_q;
  assign bus.result_we_o       = result_we_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign error_o               = error_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed scenarios followed by
// randomized start/clear/host-write traffic, compared every cycle against a
// run-timeline reference model (expected outputs derived from the cycle offset
// since the accepted start).
module tb_matmul_sequencer;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BUS_WIDTH  = 64;
  localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned PIPE_LAT   = 2 * MAX_DIM - 1;
  localparam int unsigned KW         = $clog2(MAX_DIM) + 1;
  localparam int unsigned AW         = $clog2(MAX_DIM);

  logic          clk            = 1'b0;
  logic          rst_ni         = 1'b0;
  logic          start_i        = 1'b0;
  logic [KW-1:0] k_dim_i        = '0;
  logic          status_clear_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  matmul_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  matmul_sequencer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH),
    .PIPE_LAT   (PIPE_LAT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .k_dim_i        (k_dim_i),
    .status_clear_i (status_clear_i),
    .bus            (bus),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a run is a timeline anchored at the cycle its start was sampled.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;
  int m_t0     = 0;
  int m_k      = 0;
  int n        = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, n, got, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic step(input bit s, input int k, input bit clr, input bit req);
    int off;
    bit e_valid;
    start_i             = s;
    k_dim_i             = KW'(k);
    status_clear_i      = clr;
    bus.apb_write_req_i = req;
    @(negedge clk);
    off     = n - m_t0;
    e_valid = m_active && off >= 2 && off < 2 + m_k;
    check("busy",      32'(busy_o),                32'(m_active));
    check("acc_clear", 32'(bus.acc_clear_o),       32'(m_active && off == 1));
    check("op_valid",  32'(bus.op_valid_o),        32'(e_valid));
    check("op_addr",   32'(bus.op_addr_o),         e_valid ? 32'(off - 2) : 32'd0);
    check("result_we", 32'(bus.result_we_o),       32'(m_active && off == m_k + int'(PIPE_LAT) + 2));
    check("done",      32'(done_o),                32'(m_done));
    check("error",     32'(error_o),               32'(m_err));
    check("grant",     32'(bus.apb_grant_o),       32'(!m_active && !s));
    check("op_we",     32'(bus.op_write_enable_o), 32'(!m_active && !s && req));
    @(posedge clk);
    if (m_active) begin
      if (off == m_k + int'(PIPE_LAT) + 2) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else begin
      if (clr) begin
        m_done = 1'b0;
        m_err  = 1'b0;
      end
      if (s) begin
        if (k >= 1 && k <= int'(MAX_DIM)) begin
          m_active = 1'b1;
          m_t0     = n;
          m_k      = k;
          m_done   = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    n++;
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic mid_reset();
    start_i             = 1'b0;
    status_clear_i      = 1'b0;
    bus.apb_write_req_i = 1'b1;
    rst_ni              = 1'b0;
    #1;
    check("rst_busy",      32'(busy_o),                32'd0);
    check("rst_acc_clear", 32'(bus.acc_clear_o),       32'd0);
    check("rst_op_valid",  32'(bus.op_valid_o),        32'd0);
    check("rst_op_addr",   32'(bus.op_addr_o),         32'd0);
    check("rst_result_we", 32'(bus.result_we_o),       32'd0);
    check("rst_done",      32'(done_o),                32'd0);
    check("rst_error",     32'(error_o),               32'd0);
    check("rst_grant",     32'(bus.apb_grant_o),       32'd1);
    check("rst_op_we",     32'(bus.op_write_enable_o), 32'd1);
    m_active = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    n++;
    #1;
  endtask

  initial begin
    bus.apb_write_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",      32'(busy_o),          32'd0);
    check("reset_op_valid",  32'(bus.op_valid_o),  32'd0);
    check("reset_acc_clear", 32'(bus.acc_clear_o), 32'd0);
    check("reset_result_we", 32'(bus.result_we_o), 32'd0);
    check("reset_done",      32'(done_o),          32'd0);
    check("reset_error",     32'(error_o),         32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // k=2 run
    step(1'b1, 2, 1'b0, 1'b0);
    repeat (9) step(1'b0, 0, 1'b0, 1'b0);
    // k=1 run
    step(1'b1, 1, 1'b0, 1'b0);
    repeat (8) step(1'b0, 0, 1'b0, 1'b0);
    // illegal sizes, then clear
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    repeat (2) step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    // host write held across a run, second start at cycle 4
    step(1'b1, 2, 1'b0, 1'b1);
    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1);
    repeat (5) step(1'b0, 0, 1'b0, 1'b1);
    // clear done, then a new run clears and re-sets it
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    repeat (9) step(1'b0, 0, 1'b0, 1'b0);
    // clear coinciding with write-back: done still set
    step(1'b1, 1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 0, 1'b0, 1'b0);
    // reset at cycle 3 of a k=2 run
    step(1'b1, 2, 1'b0, 1'b0);
    repeat (2) step(1'b0, 0, 1'b0, 1'b0);
    mid_reset();
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 3) == 0,
             int'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
